// File: rtl/g16_inv_pipe.sv
// g16_inv_pipe: two-stage GF(16) inverter (normal basis) with valid/ready
// handshake and sideband tag. S1 holds the split nibble and the GF(4)
// inverse d; S2 holds the final inverse. done_cnt counts output transfers.
module g16_inv_pipe #(
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       sq_scl_in,
   input  logic [3:0]       prod_in,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       inv_out,
   output logic [TAG_W-1:0] tag_out,
   output logic [7:0]       done_cnt
);

   // GF(4) square in normal basis is a bit swap; inverse equals square.
   function automatic logic [1:0] gf4_sq(input logic [1:0] g);
      return {g[0], g[1]};
   endfunction

   // Multiply by the norm constant N.
   function automatic logic [1:0] gf4_scl_n(input logic [1:0] g);
      return {g[0], g[1] ^ g[0]};
   endfunction

   function automatic logic [1:0] gf4_mul(input logic [1:0] u, input logic [1:0] v);
      logic e;
      e = (u[1] ^ u[0]) & (v[1] ^ v[0]);
      return {(u[1] & v[1]) ^ e, (u[0] & v[0]) ^ e};
   endfunction

   logic             s1_valid;
   logic [1:0]       s1_a;
   logic [1:0]       s1_b;
   logic [1:0]       s1_d;
   logic [TAG_W-1:0] s1_tag;
   logic             s2_valid;

   logic [3:0]       x;
   logic [1:0]       a;
   logic [1:0]       b;
   logic [1:0]       c;
   logic [1:0]       d;
   logic             s2_open;
   logic             accept;

   // First half of the inversion plus handshake decode.
   always_comb begin
      x        = sq_scl_in ^ prod_in;
      a        = x[3:2];
      b        = x[1:0];
      c        = gf4_scl_n(gf4_sq(a ^ b)) ^ gf4_mul(a, b);
      d        = gf4_sq(c);
      s2_open  = !s2_valid || out_ready;
      in_ready = !rst && (!s1_valid || s2_open);
      accept   = in_valid && in_ready;
   end

   // Stage 1: capture operand on acceptance, empty when S2 takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_d     <= '0;
         s1_tag   <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_a     <= a;
         s1_b     <= b;
         s1_d     <= d;
         s1_tag   <= tag_in;
      end else if (s2_open) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: load from S1 when empty or draining; hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         inv_out  <= '0;
         tag_out  <= '0;
      end else if (s2_open) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            inv_out <= {gf4_mul(s1_d, s1_b), gf4_mul(s1_d, s1_a)};
            tag_out <= s1_tag;
         end
      end
   end

   assign out_valid = s2_valid;

   // Count output transfers, wrapping naturally at 8 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_cnt <= '0;
      end else if (s2_valid && out_ready) begin
         done_cnt <= done_cnt + 8'd1;
      end
   end

endmodule
